// File: rtl/mac_arb_pkg.sv
// mac_arb_pkg: shared types and constants for the MAC receive arbiter.
//   state_t   : arbiter FSM states (IDLE, FWD, DRAIN)
//   KEEPW     : byte-keep width of every stream
//   ABORT_MAX : saturation value of the watchdog abort counter
package mac_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int          KEEPW     = 8;
   localparam logic [15:0] ABORT_MAX = 16'hFFFF;

endpackage

// File: rtl/mac_rx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  : per-port request vector
//   last : index of the port served most recently (lowest priority now)
//   any  : at least one request is present
//   idx  : first requesting port searching upward from last+1, wrapping
module rr_pick #(
   parameter int NUM_PORTS = 2,
   parameter int IDXW      = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDXW-1:0]      last,
   output logic                 any,
   output logic [IDXW-1:0]      idx
);

   localparam logic [IDXW:0] NP = (IDXW+1)'(NUM_PORTS);

   // cand[k] is the port at distance k+1 after last; the extra bit in the
   // sum lets the wrap work for port counts that are not a power of two.
   logic [IDXW-1:0] cand [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
         logic [IDXW:0] sum;
         assign sum      = {1'b0, last} + (IDXW+1)'(gi + 1);
         assign cand[gi] = (sum >= NP) ? IDXW'(sum - NP) : sum[IDXW-1:0];
      end
   endgenerate

   // Scan from the farthest candidate down so the nearest requester wins.
   always_comb begin
      any = 1'b0;
      idx = last;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            any = 1'b1;
            idx = cand[k];
         end
      end
   end

endmodule

// File: rtl/mac_rx_arbiter.sv
// mac_rx_arbiter: packet-granular round-robin arbiter sharing one parser
// chain between NUM_PORTS MAC receive streams, with a stall watchdog.
//   clk, rst_n             : clock, asynchronous active-low reset
//   din/tkeep/tvalid/tlast : packed per-port input streams
//   tready                 : per-port accept, at most one bit high
//   out/out_keep/outvalid/tlast_out : registered output stream
//   grant                  : port currently or last granted
//   busy                   : FSM in FWD or DRAIN
//   abort_cnt              : saturating count of watchdog aborts
module mac_rx_arbiter
   import mac_arb_pkg::*;
#(
   parameter int inwidth   = 64,
   parameter int NUM_PORTS = 2,
   parameter int TIMEOUT   = 256,
   parameter int IDXW      = $clog2(NUM_PORTS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_PORTS*inwidth-1:0] din,
   input  logic [NUM_PORTS*KEEPW-1:0] tkeep,
   input  logic [NUM_PORTS-1:0]       tvalid,
   input  logic [NUM_PORTS-1:0]       tlast,
   output logic [NUM_PORTS-1:0]       tready,
   output logic [inwidth-1:0]         out,
   output logic [KEEPW-1:0]           out_keep,
   output logic                       outvalid,
   output logic                       tlast_out,
   output logic [IDXW-1:0]            grant,
   output logic                       busy,
   output logic [15:0]                abort_cnt
);

   localparam int CNTW = $clog2(TIMEOUT + 1);

   state_t              state_reg;
   logic [IDXW-1:0]     grant_reg;
   logic [CNTW-1:0]     stall_reg;
   logic [15:0]         abort_reg;
   logic [inwidth-1:0]  out_reg;
   logic [KEEPW-1:0]    keep_reg;
   logic                valid_reg;
   logic                last_reg;

   logic [inwidth-1:0]  din_arr  [NUM_PORTS];
   logic [KEEPW-1:0]    keep_arr [NUM_PORTS];

   logic                pick_any;
   logic [IDXW-1:0]     pick_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign din_arr[gi]  = din[gi*inwidth +: inwidth];
         assign keep_arr[gi] = tkeep[gi*KEEPW +: KEEPW];
         // Only the granted port is ever accepted, and only outside IDLE.
         assign tready[gi]   = (state_reg != IDLE) && (grant_reg == IDXW'(gi));
      end
   endgenerate

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDXW      (IDXW)
   ) u_pick (
      .req  (tvalid),
      .last (grant_reg),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // tready[grant] is high in FWD and DRAIN, so a valid beat is accepted.
   logic               cur_valid;
   logic               cur_last;
   logic [inwidth-1:0] cur_data;
   logic [KEEPW-1:0]   cur_keep;

   assign cur_valid = tvalid[grant_reg];
   assign cur_last  = tlast[grant_reg];
   assign cur_data  = din_arr[grant_reg];
   assign cur_keep  = keep_arr[grant_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         grant_reg <= IDXW'(NUM_PORTS - 1);
         stall_reg <= '0;
         abort_reg <= '0;
         out_reg   <= '0;
         keep_reg  <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  grant_reg <= pick_idx;
                  stall_reg <= '0;
                  state_reg <= FWD;
               end
            end
            FWD: begin
               // A beat arriving on the timeout cycle still beats the abort.
               if (cur_valid) begin
                  out_reg   <= cur_data;
                  keep_reg  <= cur_keep;
                  valid_reg <= 1'b1;
                  last_reg  <= cur_last;
                  stall_reg <= '0;
                  if (cur_last) begin
                     state_reg <= IDLE;
                  end
               end else if (stall_reg == CNTW'(TIMEOUT)) begin
                  // Synthetic empty terminator closes the packet downstream.
                  out_reg   <= '0;
                  keep_reg  <= '0;
                  valid_reg <= 1'b1;
                  last_reg  <= 1'b1;
                  stall_reg <= '0;
                  if (abort_reg != ABORT_MAX) begin
                     abort_reg <= abort_reg + 16'd1;
                  end
                  state_reg <= DRAIN;
               end else begin
                  stall_reg <= stall_reg + 1'b1;
               end
            end
            DRAIN: begin
               // Swallow the rest of the aborted packet without output.
               if (cur_valid && cur_last) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out       = out_reg;
   assign out_keep  = keep_reg;
   assign outvalid  = valid_reg;
   assign tlast_out = last_reg;
   assign grant     = grant_reg;
   assign busy      = (state_reg != IDLE);
   assign abort_cnt = abort_reg;

endmodule

// File: tb/tb_mac_rx_arbiter.sv
// tb_mac_rx_arbiter: self-checking bench for mac_rx_arbiter (2 ports,
// TIMEOUT=4). Per-port beat queues drive the inputs; every accepted beat
// pushes its expected output onto a scoreboard that is popped when the
// DUT presents outvalid.
module tb_mac_rx_arbiter;

   localparam int W  = 64;
   localparam int NP = 2;
   localparam int TO = 4;
   localparam int IW = 1;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      int          gap;
      bit          drop;
      bit          abort_after;
   } beat_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [1:0]  req;
      int          first;
      logic [63:0] data;
      logic [7:0]  keep;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NP*W-1:0]   din = '0;
   logic [NP*8-1:0]   tkeep = '0;
   logic [NP-1:0]     tvalid = '0;
   logic [NP-1:0]     tlast = '0;
   logic [NP-1:0]     tready;
   logic [W-1:0]      out;
   logic [7:0]        out_keep;
   logic              outvalid;
   logic              tlast_out;
   logic [IW-1:0]     grant;
   logic              busy;
   logic [15:0]       abort_cnt;

   mac_rx_arbiter #(
      .inwidth   (W),
      .NUM_PORTS (NP),
      .TIMEOUT   (TO),
      .IDXW      (IW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .tkeep     (tkeep),
      .tvalid    (tvalid),
      .tlast     (tlast),
      .tready    (tready),
      .out       (out),
      .out_keep  (out_keep),
      .outvalid  (outvalid),
      .tlast_out (tlast_out),
      .grant     (grant),
      .busy      (busy),
      .abort_cnt (abort_cnt)
   );

   always #5 clk = ~clk;

   beat_t pq [NP][$];
   exp_t  expq[$];
   int    served[$];
   int    exp_served[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    mon_en = 1'b0;
   bit    prev_last = 1'b0;
   bit    sop [NP];
   int    waitc [NP];
   vec_t  vt [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Advance to the next falling edge and check whatever the DUT shows.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (mon_en && rst_n) begin
         checks++;
         if ($countones(tready) > 1 || (!busy && tready != '0)) begin
            errors++;
            $display("FAIL tready_onehot cyc %0d got %b busy %b", cyc, tready, busy);
         end
         if (outvalid) begin
            checks++;
            if (prev_last) begin
               errors++;
               $display("FAIL pkt_gap cyc %0d got back-to-back packets want idle cycle", cyc);
            end
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat cyc %0d got %h/%h/%b want none", cyc, out, out_keep, tlast_out);
            end else begin
               e = expq.pop_front();
               if (out !== e.data || out_keep !== e.keep || tlast_out !== e.last ||
                   (e.cyc >= 0 && cyc != e.cyc)) begin
                  errors++;
                  $display("FAIL beat got %h/%h/%b@%0d want %h/%h/%b@%0d",
                           out, out_keep, tlast_out, cyc, e.data, e.keep, e.last, e.cyc);
               end else begin
                  $display("out cyc %0d data %h keep %h last %b", cyc, out, out_keep, tlast_out);
               end
            end
         end
         prev_last = outvalid && tlast_out;
      end
   endtask

   task automatic add_beat(input int p, input logic [63:0] d, input logic [7:0] k,
                           input logic l, input int gap, input bit drop, input bit ab);
      beat_t b;
      b.data = d; b.keep = k; b.last = l; b.gap = gap; b.drop = drop; b.abort_after = ab;
      pq[p].push_back(b);
   endtask

   // Drive all queued beats, recording expectations at each handshake.
   task automatic run(input int budget);
      int    n;
      bit    hs [NP];
      beat_t b;
      exp_t  e;
      n = 0;
      for (int p = 0; p < NP; p++) waitc[p] = 0;
      forever begin
         if (pq[0].size() == 0 && pq[1].size() == 0 && expq.size() == 0) break;
         if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL run_timeout got %0d cycles want fewer, pending %0d/%0d/%0d",
                     n, pq[0].size(), pq[1].size(), expq.size());
            for (int p = 0; p < NP; p++) pq[p].delete();
            expq.delete();
            break;
         end
         for (int p = 0; p < NP; p++) begin
            hs[p] = 1'b0;
            tvalid[p] = 1'b0;
            if (pq[p].size() > 0) begin
               b = pq[p][0];
               if (waitc[p] < b.gap) begin
                  waitc[p]++;
               end else begin
                  tvalid[p] = 1'b1;
                  din[p*W +: W] = b.data;
                  tkeep[p*8 +: 8] = b.keep;
                  tlast[p] = b.last;
               end
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (tvalid[p] && tready[p]) begin
               hs[p] = 1'b1;
               b = pq[p][0];
               if (!b.drop) begin
                  e.data = b.data; e.keep = b.keep; e.last = b.last; e.cyc = cyc + 1;
                  expq.push_back(e);
                  if (sop[p]) served.push_back(p);
               end
               if (b.abort_after) begin
                  e.data = '0; e.keep = '0; e.last = 1'b1; e.cyc = -1;
                  expq.push_back(e);
               end
               sop[p] = b.last;
            end
         end
         tick();
         n++;
         for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
               void'(pq[p].pop_front());
               waitc[p] = 0;
            end
         end
      end
      tvalid = '0;
   endtask

   task automatic check_served(input string nm);
      chk({nm, "_count"}, 64'(served.size()), 64'(exp_served.size()));
      for (int i = 0; i < exp_served.size() && i < served.size(); i++) begin
         chk($sformatf("%s_grant%0d", nm, i), 64'(served[i]), 64'(exp_served[i]));
      end
      served.delete();
      exp_served.delete();
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         sop[p] = 1'b1;
         waitc[p] = 0;
      end

      // Reset values while rst_n is held low.
      tick(); tick(); tick();
      chk("rst_outvalid", 64'(outvalid), 64'd0);
      chk("rst_out", out, 64'd0);
      chk("rst_keep", 64'(out_keep), 64'd0);
      chk("rst_tlast", 64'(tlast_out), 64'd0);
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_abort", 64'(abort_cnt), 64'd0);
      chk("rst_grant", 64'(grant), 64'd1);
      rst_n = 1'b1;
      mon_en = 1'b1;
      tick();

      // Single-beat packets; expected first grant follows rotating priority.
      vt[0] = '{req: 2'b01, first: 0, data: 64'h1111_0000_0000_0010, keep: 8'hFF};
      vt[1] = '{req: 2'b11, first: 1, data: 64'h2222_0000_0000_0020, keep: 8'h01};
      vt[2] = '{req: 2'b10, first: 1, data: 64'h3333_0000_0000_0030, keep: 8'h00};
      vt[3] = '{req: 2'b11, first: 0, data: 64'h4444_0000_0000_0040, keep: 8'h0F};
      vt[4] = '{req: 2'b01, first: 0, data: 64'h5555_0000_0000_0050, keep: 8'h80};
      vt[5] = '{req: 2'b01, first: 0, data: 64'h6666_0000_0000_0060, keep: 8'h3C};
      vt[6] = '{req: 2'b11, first: 1, data: 64'h7777_0000_0000_0070, keep: 8'hFF};
      vt[7] = '{req: 2'b10, first: 1, data: 64'h8888_0000_0000_0080, keep: 8'h00};
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < NP; p++) begin
            if (vt[i].req[p]) add_beat(p, vt[i].data ^ 64'(p), vt[i].keep, 1'b1, 0, 1'b0, 1'b0);
         end
         run(60);
         chk($sformatf("rr_first%0d", i), (served.size() > 0) ? 64'(served[0]) : '1, 64'(vt[i].first));
         if (vt[i].req == 2'b11) begin
            chk($sformatf("rr_second%0d", i), (served.size() > 1) ? 64'(served[1]) : '1,
                64'(1 - vt[i].first));
         end
         $display("vec %0d req %b first %0d", i, vt[i].req, vt[i].first);
         served.delete();
      end

      // Both ports with back-to-back 2-beat packets: grants alternate.
      add_beat(0, 64'hA0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hA1, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
      add_beat(0, 64'hC0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hC1, 8'h07, 1'b1, 0, 1'b0, 1'b0);
      add_beat(1, 64'hB0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(1, 64'hB1, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
      add_beat(1, 64'hD0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(1, 64'hD1, 8'h01, 1'b1, 0, 1'b0, 1'b0);
      run(80);
      exp_served = '{0, 1, 0, 1};
      check_served("alternate");

      // Single port, 3-beat packet with partial keep on the last beat.
      add_beat(0, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hCCCC_CCCC_CCCC_CCCC, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
      run(40);
      exp_served = '{0};
      check_served("single");
      chk("single_grant", 64'(grant), 64'd0);

      // Port 1 starts while port 0 is mid-packet: must wait for port 0's tlast.
      add_beat(0, 64'hE0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hE1, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hE2, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hE3, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
      add_beat(1, 64'hF0, 8'hFF, 1'b0, 2, 1'b0, 1'b0);
      add_beat(1, 64'hF1, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
      run(60);
      exp_served = '{0, 1};
      check_served("midpkt");

      // Stall of 10 cycles: terminator, abort count, late beats drained.
      add_beat(0, 64'h5101, 8'hFF, 1'b0, 0, 1'b0, 1'b1);
      add_beat(0, 64'h5102, 8'hFF, 1'b0, 10, 1'b1, 1'b0);
      add_beat(0, 64'h5103, 8'hFF, 1'b1, 0, 1'b1, 1'b0);
      run(60);
      exp_served = '{0};
      check_served("abort");
      chk("abort_cnt1", 64'(abort_cnt), 64'd1);
      chk("abort_idle", 64'(busy), 64'd0);

      // Beat arrives exactly when the stall count reaches TIMEOUT: forwarded.
      add_beat(0, 64'h6201, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'h6202, 8'hFF, 1'b0, TO, 1'b0, 1'b0);
      add_beat(0, 64'h6203, 8'h03, 1'b1, 0, 1'b0, 1'b0);
      run(60);
      exp_served = '{0};
      check_served("edge_ok");
      chk("edge_ok_abort", 64'(abort_cnt), 64'd1);

      // One cycle later is too late: abort.
      add_beat(0, 64'h7301, 8'hFF, 1'b0, 0, 1'b0, 1'b1);
      add_beat(0, 64'h7302, 8'hFF, 1'b1, TO + 1, 1'b1, 1'b0);
      run(60);
      exp_served = '{0};
      check_served("edge_late");
      chk("edge_late_abort", 64'(abort_cnt), 64'd2);
      chk("edge_late_idle", 64'(busy), 64'd0);

      // Asynchronous reset in the middle of a packet.
      mon_en = 1'b0;
      tvalid[0] = 1'b1;
      tlast[0] = 1'b0;
      din[0 +: W] = 64'h9999;
      tkeep[0 +: 8] = 8'hFF;
      tick(); tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_outvalid", 64'(outvalid), 64'd0);
      chk("arst_out", out, 64'd0);
      chk("arst_keep", 64'(out_keep), 64'd0);
      chk("arst_tready", 64'(tready), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_abort", 64'(abort_cnt), 64'd0);
      chk("arst_grant", 64'(grant), 64'd1);
      tvalid = '0;
      tlast = '0;
      tick(); tick();
      rst_n = 1'b1;
      expq.delete();
      for (int p = 0; p < NP; p++) sop[p] = 1'b1;
      prev_last = 1'b0;
      mon_en = 1'b1;
      add_beat(0, 64'hAB01, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hAB02, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
      add_beat(0, 64'hAB03, 8'h1F, 1'b1, 0, 1'b0, 1'b0);
      add_beat(1, 64'hCD01, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
      run(60);
      exp_served = '{0, 1};
      check_served("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_rx_arbiter.md
Name: mac_rx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one Ethernet/IP parser chain between NUM_PORTS MAC receive streams.
- Sits in front of the Ethernet-layer stripper. Forwards each packet contiguously, whole, from one port at a time.
- The downstream chain has no backpressure, so the arbiter must never interleave beats from different ports.
- A stall watchdog force-terminates a packet whose source goes silent mid-frame.

Parameters:
- inwidth, 64, data beat width in bits; the keep width is always 8.
- NUM_PORTS, 2, number of MAC input streams; must be at least 2.
- TIMEOUT, 256, consecutive idle cycles inside a packet before it is aborted; minimum 1.
- IDXW, $clog2(NUM_PORTS), width of the port index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NUM_PORTS*inwidth  port p data at [p*inwidth +: inwidth].
- tkeep  input  NUM_PORTS*8  port p byte keep at [p*8 +: 8].
- tvalid  input  NUM_PORTS  per-port beat valid.
- tlast  input  NUM_PORTS  per-port last beat of packet.
- tready  output  NUM_PORTS  per-port accept; a beat transfers when tvalid and tready are both high.
- out  output  inwidth  data to the Ethernet layer.
- out_keep  output  8  keep to the Ethernet layer.
- outvalid  output  1  beat valid to the Ethernet layer.
- tlast_out  output  1  last beat to the Ethernet layer.
- grant  output  IDXW  port currently or last granted.
- busy  output  1  high while in FWD or DRAIN.
- abort_cnt  output  16  saturating count of watchdog aborts.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: out=0, out_keep=0, outvalid=0, tlast_out=0, tready=0, busy=0, abort_cnt=0.
  - State: state=IDLE, grant=NUM_PORTS-1, so port 0 has first priority.
- Reset mid-packet drops the partial packet with no tlast_out. After release, the arbiter restarts cleanly in IDLE.
- States: IDLE, FWD, DRAIN.
- IDLE:
  - tready is all zero.
  - A request is tvalid[p]=1.
  - If any request exists, pick the first requester searching from grant+1 upward, wrapping modulo NUM_PORTS. Load grant, go to FWD.
  - With no requests, stay in IDLE and hold grant.
- FWD:
  - tready[grant]=1; all other tready bits are 0.
  - Each accepted beat is registered onto out/out_keep/tlast_out with outvalid=1 on the next cycle. Latency is exactly 1 cycle.
  - outvalid is 0 in any cycle following no transfer.
  - Data and keep pass unmodified, including keep=0 beats.
  - An accepted beat with tlast=1 returns the FSM to IDLE. The result is at least one outvalid=0 cycle between packets.
- Watchdog (FWD only):
  - The stall counter clears on every accepted beat and on FWD entry. It increments while tvalid[grant]=0.
  - When the counter reaches TIMEOUT, the next cycle emits a synthetic terminator: outvalid=1, tlast_out=1, out_keep=0, out=0.
  - The same cycle increments abort_cnt, saturating at 16'hFFFF. The FSM then goes to DRAIN.
  - If the stalled beat arrives in the same cycle the count reaches TIMEOUT, the beat wins: it is forwarded and there is no abort.
- DRAIN:
  - tready[grant]=1 and outvalid=0.
  - Accepted beats are discarded.
  - On an accepted tlast the FSM goes to IDLE. DRAIN has no timeout.
- Fairness:
  - A port just served is lowest priority on the next arbitration.
  - A single active port is re-granted after 1 idle cycle.
- busy=1 exactly when state is FWD or DRAIN.
- Only one tready bit is ever high; none is high in IDLE.

Decomposition:
- Package mac_arb_pkg holds:
  - a state_t enum (IDLE, FWD, DRAIN);
  - KEEPW=8;
  - ABORT_MAX=16'hFFFF.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req[NUM_PORTS], last[IDXW].
  - Outputs: any, idx.
- The top holds the FSM, the output register, the stall counter and abort_cnt.

Test Plan:
- Single port, 3-beat packet on port 0 (data A,B,C; last keep 8'h0F):
  - out shows A,B,C on consecutive cycles, each 1 cycle after transfer, with tlast_out and keep 8'h0F on C.
  - grant=0.
- Both ports hold continuous 2-beat packets:
  - grant alternates 0,1,0,1.
  - Each packet emerges contiguous with one idle cycle between packets.
  - tready is never high on both ports at once.
- Port 1 packet starts while port 0 is mid-packet:
  - port 1 tready stays 0 until port 0 delivers tlast.
  - Port 1 is then granted next, and no beats interleave.
- TIMEOUT=4; port 0 sends 1 beat then drops tvalid for 10 cycles, then sends 2 more beats ending in tlast:
  - after the first beat, a terminator (keep 0, tlast_out=1) appears and abort_cnt=1.
  - The 2 late beats are drained with outvalid=0.
  - FSM returns to IDLE.
- Stalled beat arrives exactly at count TIMEOUT:
  - the beat is forwarded, abort_cnt is unchanged, and there is no terminator.
- rst_n pulsed low mid-packet:
  - all outputs zero immediately (async).
  - After release, the next request on port 0 is granted first, and a full packet forwards cleanly.
